vga_fb_arbiter: RTL

//  Owns the single-port framebuffer RAM behind vga_sync. Sequences pixel fetches from

---
 rtl/vga_pkg.sv | 31 +++
 rtl/vga_sync_delay.sv | 28 ++
 rtl/vga_fb_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared types, default geometry and helpers for the framebuffer arbiter.
package vga_pkg;

  localparam int H_ACTIVE_DEF  = 800;
  localparam int V_ACTIVE_DEF  = 600;
  localparam int PIX_W_DEF     = 8;
  localparam int FB_ADDR_W_DEF = 19;
  localparam int X_W           = 11;
  localparam int Y_W           = 10;

  typedef enum logic [0:0] {
    SW_IDLE = 1'b0,
    SW_PEND = 1'b1
  } swap_state_t;

  // Multiply by a constant as a sum of shifted copies; with k constant this
  // unrolls into a small adder tree instead of a hard multiplier.
  function automatic logic [31:0] fb_mul(input logic [31:0] a, input logic [31:0] k);
    logic [31:0] acc;
    acc = 32'd0;
    for (int i = 0; i < 32; i++) begin
      if (k[i]) begin
        acc = acc + (a << i);
      end else begin
        acc = acc;
      end
    end
    return acc;
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Fixed-depth shift register keeping sync/display_on aligned with the pixel path.
module vga_sync_delay #(
  parameter int DEPTH = 2,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [DEPTH-1:0][W-1:0] pipe;

  // Shift the sync bundle one stage per pixel clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/vga_fb_arbiter.sv
// Framebuffer port owner: display fetches first, host writes in the free
// slots, double-buffered page flip at vertical-blank start, and a 2-cycle
// aligned pixel/sync output path.
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int SCALE_SHIFT = 0,
  parameter int PIX_W       = PIX_W_DEF,
  parameter int FB_ADDR_W   = FB_ADDR_W_DEF
) (
  input  logic                 vga_clk_in,
  input  logic                 reset_n_in,
  input  logic                 h_sync_in,
  input  logic                 v_sync_in,
  input  logic                 display_on_in,
  input  logic [X_W-1:0]       pixel_x_in,
  input  logic [Y_W-1:0]       pixel_y_in,
  input  logic                 host_valid_in,
  input  logic [FB_ADDR_W-1:0] host_addr_in,
  input  logic [PIX_W-1:0]     host_data_in,
  output logic                 host_ready_out,
  input  logic                 swap_req_in,
  output logic                 swap_done_out,
  output logic                 front_page_out,
  output logic [FB_ADDR_W:0]   mem_addr_out,
  output logic                 mem_we_out,
  output logic [PIX_W-1:0]     mem_wdata_out,
  input  logic [PIX_W-1:0]     mem_rdata_in,
  output logic                 h_sync_out,
  output logic                 v_sync_out,
  output logic                 display_on_out,
  output logic [PIX_W-1:0]     rgb_out
);

  localparam int             FB_W   = H_ACTIVE >> SCALE_SHIFT;
  localparam logic [X_W-1:0] X_MASK = X_W'((32'd1 << SCALE_SHIFT) - 32'd1);

  logic                 fetch_need;
  logic                 host_fire;
  logic                 vblank_start;
  logic [31:0]          row_wide;
  logic [31:0]          col_wide;
  logic [FB_ADDR_W-1:0] fetch_offset;
  logic                 fetch_d1;
  logic                 disp_d1;
  logic [PIX_W-1:0]     pix_reg;
  logic [PIX_W-1:0]     pix_next;
  swap_state_t          swap_state;

  // Only the first pixel of each downscaled block needs a RAM read.
  assign fetch_need     = display_on_in && ((pixel_x_in & X_MASK) == {X_W{1'b0}});
  assign host_ready_out = !fetch_need;
  assign host_fire      = host_valid_in && !fetch_need;
  assign vblank_start   = (pixel_y_in == Y_W'(V_ACTIVE)) && (pixel_x_in == {X_W{1'b0}});

  assign row_wide     = 32'(pixel_y_in) >> SCALE_SHIFT;
  assign col_wide     = 32'(pixel_x_in) >> SCALE_SHIFT;
  assign fetch_offset = FB_ADDR_W'(fb_mul(row_wide, 32'(FB_W)) + col_wide);

  // RAM port: display fetch wins, host write uses the slot otherwise, address holds when idle.
  always_ff @(posedge vga_clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      mem_addr_out  <= '0;
      mem_we_out    <= 1'b0;
      mem_wdata_out <= '0;
    end else if (fetch_need) begin
      mem_addr_out <= {front_page_out, fetch_offset};
      mem_we_out   <= 1'b0;
    end else if (host_fire) begin
      mem_addr_out  <= {~front_page_out, host_addr_in};
      mem_we_out    <= 1'b1;
      mem_wdata_out <= host_data_in;
    end else begin
      mem_we_out <= 1'b0;
    end
  end

  // New pixel arrives on the cycle after a fetch; otherwise replicate the last one.
  always_comb begin
    pix_next = pix_reg;
    if (fetch_d1) begin
      pix_next = mem_rdata_in;
    end else begin
      pix_next = pix_reg;
    end
  end

  // Pixel register and blanked rgb output, two cycles behind the input sample.
  always_ff @(posedge vga_clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      fetch_d1 <= 1'b0;
      disp_d1  <= 1'b0;
      pix_reg  <= '0;
      rgb_out  <= '0;
    end else begin
      fetch_d1 <= fetch_need;
      disp_d1  <= display_on_in;
      pix_reg  <= pix_next;
      rgb_out  <= disp_d1 ? pix_next : {PIX_W{1'b0}};
    end
  end

  // Page-swap FSM: a request waits for vertical-blank start, then flips once.
  always_ff @(posedge vga_clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      swap_state     <= SW_IDLE;
      front_page_out <= 1'b0;
      swap_done_out  <= 1'b0;
    end else begin
      swap_done_out <= 1'b0;
      case (swap_state)
        SW_IDLE: begin
          if (swap_req_in && vblank_start) begin
            front_page_out <= ~front_page_out;
            swap_done_out  <= 1'b1;
            swap_state     <= SW_IDLE;
          end else if (swap_req_in) begin
            swap_state <= SW_PEND;
          end else begin
            swap_state <= SW_IDLE;
          end
        end
        SW_PEND: begin
          if (vblank_start) begin
            front_page_out <= ~front_page_out;
            swap_done_out  <= 1'b1;
            swap_state     <= SW_IDLE;
          end else begin
            swap_state <= SW_PEND;
          end
        end
        default: begin
          swap_state <= SW_IDLE;
        end
      endcase
    end
  end

  vga_sync_delay #(
    .DEPTH(2),
    .W    (3)
  ) u_sync_delay (
    .clk    (vga_clk_in),
    .reset_n(reset_n_in),
    .din    ({h_sync_in, v_sync_in, display_on_in}),
    .dout   ({h_sync_out, v_sync_out, display_on_out})
  );

endmodule
